// File: rtl/la_capture_ctrl.sv
// -----------------------------------------------------------------------------
// la_capture_ctrl
//   Capture sequencer for the 16-channel logic analyser. It takes the
//   registered pin samples from the input frontend, decimates them with a
//   programmable strobe, and writes them circularly into the sample RAM while
//   armed. It then looks for a masked trigger pattern, stores a programmed
//   number of post-trigger samples, and halts. The host-side readout logic uses
//   the trigger address it reports.
//
// Parameters
//   WIDTH   sample / channel width
//   ADDR_W  sample RAM address width (depth = 2**ADDR_W)
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   arm          pulse: start a capture from IDLE or DONE
//   abort        pulse: cancel any capture and return to IDLE (wins over arm)
//   rate_div     one strobe every rate_div+1 clocks
//   pre_count    samples that must be written before a trigger is accepted
//   post_count   samples written after the trigger sample
//   trig_mask    1 = channel takes part in the trigger compare
//   trig_value   required level on the masked channels
//   sample       registered pin sample
//   mem_we/mem_addr/mem_data   sample RAM write port (registered)
//   busy         capture in progress (ARMED or POST)
//   triggered    trigger seen; held until the next arm, abort or rst
//   done         capture complete
//   trig_addr    RAM address that holds the trigger sample
// -----------------------------------------------------------------------------
module la_capture_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [15:0]       rate_div,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [WIDTH-1:0]  trig_mask,
  input  logic [WIDTH-1:0]  trig_value,
  input  logic [WIDTH-1:0]  sample,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   X_ONE = (ADDR_W + 1)'(1);

  state_t state, state_d;

  logic [ADDR_W-1:0] wptr;
  logic [15:0]       div_cnt;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] post_cnt;

  // Control settings captured at arm, stable for the whole capture.
  logic [15:0]       rate_l;
  logic [ADDR_W-1:0] pre_l;
  logic [ADDR_W-1:0] post_l;
  logic [WIDTH-1:0]  mask_l;
  logic [WIDTH-1:0]  value_l;

  logic active;
  logic arm_start;
  logic strobe;
  logic hit;
  logic post_last;

  function automatic logic trig_match(input logic [WIDTH-1:0] s,
                                      input logic [WIDTH-1:0] v,
                                      input logic [WIDTH-1:0] m);
    return ((s ^ v) & m) == '0;
  endfunction

  always_comb begin
    active    = (state == S_ARMED) || (state == S_POST);
    arm_start = arm && ((state == S_IDLE) || (state == S_DONE));
    strobe    = active && (div_cnt == rate_l);
    // A trigger is only accepted once the pre-trigger window has been filled.
    hit       = strobe && (state == S_ARMED) && (fill_cnt == pre_l) &&
                trig_match(sample, value_l, mask_l);
    // Widened compare so post_count at full scale cannot wrap.
    post_last = strobe && (state == S_POST) &&
                (({1'b0, post_cnt} + X_ONE) == {1'b0, post_l});

    state_d = state;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (arm) state_d = S_ARMED;
        S_DONE:  if (arm) state_d = S_ARMED;
        S_ARMED: if (hit) state_d = (post_l == '0) ? S_DONE : S_POST;
        S_POST:  if (post_last) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wptr      <= '0;
      div_cnt   <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      rate_l    <= '0;
      pre_l     <= '0;
      post_l    <= '0;
      mask_l    <= '0;
      value_l   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      trig_addr <= '0;
    end else begin
      state  <= state_d;
      busy   <= (state_d == S_ARMED) || (state_d == S_POST);
      done   <= (state_d == S_DONE);
      mem_we <= 1'b0;

      if (abort || arm_start) begin
        wptr      <= '0;
        div_cnt   <= '0;
        fill_cnt  <= '0;
        post_cnt  <= '0;
        triggered <= 1'b0;
        if (!abort) begin
          rate_l  <= rate_div;
          pre_l   <= pre_count;
          post_l  <= post_count;
          mask_l  <= trig_mask;
          value_l <= trig_value;
        end
      end else if (active) begin
        div_cnt <= strobe ? 16'd0 : div_cnt + 16'd1;
        if (strobe) begin
          mem_we   <= 1'b1;
          mem_addr <= wptr;
          mem_data <= sample;
          wptr     <= wptr + A_ONE;
          if ((state == S_ARMED) && (fill_cnt != pre_l))
            fill_cnt <= fill_cnt + A_ONE;
          if (hit) begin
            trig_addr <= wptr;
            triggered <= 1'b1;
          end
          if (state == S_POST)
            post_cnt <= post_cnt + A_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_la_capture_ctrl
//   Directed bench for la_capture_ctrl. Two instances share all stimulus:
//   u_dut uses the default 10-bit address and u_dut4 uses a 4-bit address so
//   that RAM wrap-around can be seen after a short run.
// -----------------------------------------------------------------------------
module tb_la_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] rate_div = '0;
  logic [9:0]  pre_count = '0;
  logic [9:0]  post_count = '0;
  logic [15:0] trig_mask = '0;
  logic [15:0] trig_value = '0;
  logic [15:0] sample = '0;

  logic        mem_we, busy, triggered, done;
  logic [9:0]  mem_addr, trig_addr;
  logic [15:0] mem_data;

  logic        mem_we4, busy4, triggered4, done4;
  logic [3:0]  mem_addr4, trig_addr4;
  logic [15:0] mem_data4;

  la_capture_ctrl #(.WIDTH(16), .ADDR_W(10)) u_dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .rate_div(rate_div),
    .pre_count(pre_count), .post_count(post_count), .trig_mask(trig_mask),
    .trig_value(trig_value), .sample(sample), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy),
    .triggered(triggered), .done(done), .trig_addr(trig_addr)
  );

  la_capture_ctrl #(.WIDTH(16), .ADDR_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .rate_div(rate_div),
    .pre_count(pre_count[3:0]), .post_count(post_count[3:0]),
    .trig_mask(trig_mask), .trig_value(trig_value), .sample(sample),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_data(mem_data4),
    .busy(busy4), .triggered(triggered4), .done(done4),
    .trig_addr(trig_addr4)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-run write log and stimulus knobs.
  int wa[$];
  int wd[$];
  int wc[$];
  int w4[$];
  int done_c;
  int done_we;
  int done_addr;
  int hi_from = 1000;
  int arm_at  = -1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Cycle c drives sample bit0 high once c >= hi_from; upper bits carry c.
  task automatic run(input int n);
    wa.delete(); wd.delete(); wc.delete(); w4.delete();
    done_c = -1; done_we = 0; done_addr = -1;
    for (int c = 0; c < n; c++) begin
      sample = {c[11:0], (c >= hi_from) ? 4'h1 : 4'h0};
      arm    = (c == arm_at);
      tick();
      arm = 1'b0;
      if (mem_we) begin
        wa.push_back(int'(mem_addr));
        wd.push_back(int'(mem_data));
        wc.push_back(c);
      end
      if (mem_we4) w4.push_back(int'(mem_addr4));
      if (done && done_c < 0) begin
        done_c    = c;
        done_we   = int'(mem_we);
        done_addr = int'(mem_addr);
      end
    end
  endtask

  function automatic int qa(input int i);
    return (i < wa.size()) ? wa[i] : -1;
  endfunction

  task automatic cfg(input int rd, input int pre, input int post,
                     input int mask, input int val, input int hi);
    rate_div   = 16'(rd);
    pre_count  = 10'(pre);
    post_count = 10'(post);
    trig_mask  = 16'(mask);
    trig_value = 16'(val);
    hi_from    = hi;
    arm_at     = -1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},   32'(mem_we),    32'd0);
    chk({tag, "_addr"}, 32'(mem_addr),  32'd0);
    chk({tag, "_data"}, 32'(mem_data),  32'd0);
    chk({tag, "_busy"}, 32'(busy),      32'd0);
    chk({tag, "_trg"},  32'(triggered), 32'd0);
    chk({tag, "_done"}, 32'(done),      32'd0);
    chk({tag, "_taddr"},32'(trig_addr), 32'd0);
  endtask

  task automatic check_t2(input string tag);
    chk({tag, "_nwr"}, 32'(wa.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk({tag, "_addr"}, 32'(qa(i)), 32'(i));
    chk({tag, "_trgdata"}, 32'((wd.size() > 4) ? wd[4] : -1), 32'h0041);
    chk({tag, "_taddr"}, 32'(trig_addr), 32'd4);
    chk({tag, "_trg"},   32'(triggered), 32'd1);
    chk({tag, "_donec"}, 32'(done_c),    32'd7);
    chk({tag, "_donewe"},32'(done_we),   32'd1);
    chk({tag, "_donea"}, 32'(done_addr), 32'd7);
    chk({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check_zero("rst");
    rst = 1'b0;
    tick();
    check_zero("idle");

    // Pre-trigger window gating: bit0 high from the 2nd strobe, accepted at write 4
    cfg(0, 4, 3, 16'h0001, 16'h0001, 1);
    do_arm();
    chk("t2_busy_arm", 32'(busy), 32'd1);
    run(12);
    check_t2("t2");

    // arm pulse during POST is ignored
    cfg(0, 4, 3, 16'h0001, 16'h0001, 1);
    do_arm();
    arm_at = 5;
    run(12);
    check_t2("t6");

    // Decimated strobe, mask=0 triggers on the first eligible sample
    cfg(3, 0, 2, 0, 0, 1000);
    do_arm();
    run(16);
    chk("t3_nwr", 32'(wa.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_addr", 32'(qa(i)), 32'(i));
      chk("t3_cyc", 32'((i < wc.size()) ? wc[i] : -1), 32'(4 * i + 3));
    end
    chk("t3_taddr", 32'(trig_addr), 32'd0);
    chk("t3_donec", 32'(done_c), 32'd11);

    // rst in the middle of POST, then a normal capture
    cfg(0, 4, 3, 16'h0001, 16'h0001, 1);
    do_arm();
    run(6);
    chk("t1_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("t1");
    do_arm();
    run(12);
    check_t2("t1re");

    // Wrap-around with the 4-bit instance
    cfg(0, 2, 1, 16'h0001, 16'h0001, 20);
    do_arm();
    run(26);
    chk("t4_nwr4", 32'(w4.size()), 32'd22);
    chk("t4_a15", 32'((w4.size() > 15) ? w4[15] : -1), 32'd15);
    chk("t4_a16", 32'((w4.size() > 16) ? w4[16] : -1), 32'd0);
    chk("t4_a21", 32'((w4.size() > 21) ? w4[21] : -1), 32'd5);
    chk("t4_taddr4", 32'(trig_addr4), 32'd4);
    chk("t4_trg4", 32'(triggered4), 32'd1);
    chk("t4_done4", 32'(done4), 32'd1);
    chk("t4_taddr", 32'(trig_addr), 32'd20);

    // abort together with arm from DONE
    abort = 1'b1;
    arm   = 1'b1;
    tick();
    abort = 1'b0;
    arm   = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_trg",  32'(triggered), 32'd0);
    chk("t5_we",   32'(mem_we), 32'd0);
    cfg(0, 0, 0, 0, 0, 1000);
    run(4);
    chk("t5_nwr_idle", 32'(wa.size()), 32'd0);
    chk("t5_busy_idle", 32'(busy), 32'd0);
    do_arm();
    run(4);
    chk("t5_nwr", 32'(wa.size()), 32'd1);
    chk("t5_addr0", 32'(qa(0)), 32'd0);
    chk("t5_donec", 32'(done_c), 32'd0);
    chk("t5_taddr", 32'(trig_addr), 32'd0);
    chk("t5_trg_end", 32'(triggered), 32'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
